// File: rtl/instruction_decode_control_pkg.sv
// Shared decode definitions for the ID stage: opcodes, instruction field
// positions, controller state encoding and the ID/EX bubble.
package instruction_decode_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int JT_HI  = 25;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

endpackage

// File: rtl/instruction_decode_control_hazard_detect.sv
// Combinational RAW hazard check of the ID-stage sources against the ID/EX
// destination; shared with the forwarding unit.
module hazard_detect #(
  parameter int REG_BITS = 5
) (
  input  logic                uses_rs,
  input  logic                uses_rt,
  input  logic                is_beq,
  input  logic [REG_BITS-1:0] rs,
  input  logic [REG_BITS-1:0] rt,
  input  logic [REG_BITS-1:0] ex_dest,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  output logic                stall,
  output logic [1:0]          stall_cycles
);

  logic hit;

  always_comb begin
    hit = (ex_dest != '0) &&
          ((uses_rs && (rs == ex_dest)) || (uses_rt && (rt == ex_dest)));
    stall        = 1'b0;
    stall_cycles = 2'd0;
    // A branch needs its operands in ID, so a load feeding it costs one extra cycle.
    if (hit && ex_mem_read) begin
      stall        = 1'b1;
      stall_cycles = is_beq ? 2'd2 : 2'd1;
    end else if (hit && is_beq && ex_reg_write) begin
      stall        = 1'b1;
      stall_cycles = 2'd1;
    end
  end

endmodule

// File: rtl/instruction_decode_control.sv
// ID-stage controller: decodes IF/ID, resolves BEQ/J, stalls on hazards,
// squashes the wrong-path fetch and loads the ID/EX register.
module instruction_decode_control
  import instruction_decode_control_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [WIDTH-1:0]    programCounterOut,
  input  logic [WIDTH-1:0]    instruction,
  input  logic [WIDTH-1:0]    rsData,
  input  logic [WIDTH-1:0]    rtData,
  output logic                pcWrite,
  output logic                ifIdWrite,
  output logic                branch,
  output logic [WIDTH-1:0]    branchProgramCounter,
  output logic                idExRegWrite,
  output logic                idExMemRead,
  output logic                idExMemWrite,
  output logic [REG_BITS-1:0] idExDestReg,
  output logic [WIDTH-1:0]    idExRsData,
  output logic [WIDTH-1:0]    idExRtData,
  output logic [WIDTH-1:0]    idExImm,
  output logic [5:0]          idExFunct
);

  state_e              state_q, state_d;
  logic [1:0]          stall_cnt_q, stall_cnt_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [REG_BITS-1:0] dest_q, dest_d;
  logic [WIDTH-1:0]    rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [5:0]          funct_q, funct_d;

  logic [5:0]          op;
  logic [REG_BITS-1:0] rs, rt, rd;
  logic [WIDTH-1:0]    imm_sext, beq_tgt, j_tgt;
  logic                is_beq, uses_rs, uses_rt, taken, hold, evaluate;
  logic                hz_stall;
  logic [1:0]          hz_cycles;
  ctrl_t               dec_ctrl;
  logic [REG_BITS-1:0] dec_dest;
  logic                dec_valid;

  assign op       = instruction[OP_HI:OP_LO];
  assign rs       = REG_BITS'(instruction[RS_HI:RS_LO]);
  assign rt       = REG_BITS'(instruction[RT_HI:RT_LO]);
  assign rd       = REG_BITS'(instruction[RD_HI:RD_LO]);
  assign imm_sext = {{(WIDTH-16){instruction[IMM_HI]}}, instruction[IMM_HI:IMM_LO]};
  assign beq_tgt  = programCounterOut + (imm_sext << 2);
  assign j_tgt    = {programCounterOut[WIDTH-1:28], instruction[JT_HI:0], 2'b00};
  assign is_beq   = (op == OP_BEQ);
  assign uses_rs  = (op != OP_J);
  assign uses_rt  = (op == OP_RTYPE) || (op == OP_SW) || is_beq;
  assign taken    = (op == OP_J) || (is_beq && (rsData == rtData));

  // STALL with count 0 is the last held cycle's successor: the held
  // instruction is re-decoded in that cycle instead of stalling again.
  assign hold     = (state_q == STALL) && (stall_cnt_q != 2'd0);
  assign evaluate = (state_q == RUN) || ((state_q == STALL) && (stall_cnt_q == 2'd0));

  hazard_detect #(.REG_BITS(REG_BITS)) u_hazard (
    .uses_rs      (uses_rs),
    .uses_rt      (uses_rt),
    .is_beq       (is_beq),
    .rs           (rs),
    .rt           (rt),
    .ex_dest      (dest_q),
    .ex_reg_write (ctrl_q.reg_write),
    .ex_mem_read  (ctrl_q.mem_read),
    .stall        (hz_stall),
    .stall_cycles (hz_cycles)
  );

  always_comb begin
    dec_ctrl  = CTRL_BUBBLE;
    dec_dest  = '0;
    dec_valid = 1'b0;
    unique case (op)
      OP_RTYPE: if (instruction != '0) begin
        dec_valid          = 1'b1;
        dec_dest           = rd;
        dec_ctrl.reg_write = (rd != '0);
      end
      OP_LW: begin
        dec_valid          = 1'b1;
        dec_dest           = rt;
        dec_ctrl.reg_write = (rt != '0);
        dec_ctrl.mem_read  = 1'b1;
      end
      OP_SW: begin
        dec_valid          = 1'b1;
        dec_ctrl.mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= RUN;
      stall_cnt_q <= 2'd0;
      ctrl_q      <= CTRL_BUBBLE;
      dest_q      <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      funct_q     <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      ctrl_q      <= ctrl_d;
      dest_q      <= dest_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      funct_q     <= funct_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      RUN, STALL: begin
        if (hold) begin
          stall_cnt_d = stall_cnt_q - 2'd1;
        end else if (hz_stall) begin
          state_d     = STALL;
          stall_cnt_d = hz_cycles - 2'd1;
        end else if (taken) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pcWrite              = 1'b1;
    ifIdWrite            = 1'b1;
    branch               = 1'b0;
    branchProgramCounter = '0;
    ctrl_d               = CTRL_BUBBLE;
    dest_d               = '0;
    rs_data_d            = '0;
    rt_data_d            = '0;
    imm_d                = '0;
    funct_d              = '0;
    if (!resetN) begin
      pcWrite = 1'b1;
    end else if (hold || (evaluate && hz_stall)) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
    end else if (evaluate && taken) begin
      branch               = 1'b1;
      branchProgramCounter = (op == OP_J) ? j_tgt : beq_tgt;
    end else if (evaluate && dec_valid) begin
      ctrl_d    = dec_ctrl;
      dest_d    = dec_dest;
      rs_data_d = rsData;
      rt_data_d = rtData;
      imm_d     = imm_sext;
      funct_d   = instruction[FN_HI:FN_LO];
    end
  end

  assign idExRegWrite = ctrl_q.reg_write;
  assign idExMemRead  = ctrl_q.mem_read;
  assign idExMemWrite = ctrl_q.mem_write;
  assign idExDestReg  = dest_q;
  assign idExRsData   = rs_data_q;
  assign idExRtData   = rt_data_q;
  assign idExImm      = imm_q;
  assign idExFunct    = funct_q;

endmodule

// File: tb/tb_instruction_decode_control.sv
// Directed and random checks of the ID-stage controller against a
// cycle-level behavioural model of the pipeline rules.
module tb_instruction_decode_control;
  localparam int WIDTH    = 32;
  localparam int REG_BITS = 5;

  logic                clk = 1'b0;
  logic                resetN;
  logic [WIDTH-1:0]    programCounterOut, instruction, rsData, rtData;
  logic                pcWrite, ifIdWrite, branch;
  logic [WIDTH-1:0]    branchProgramCounter;
  logic                idExRegWrite, idExMemRead, idExMemWrite;
  logic [REG_BITS-1:0] idExDestReg;
  logic [WIDTH-1:0]    idExRsData, idExRtData, idExImm;
  logic [5:0]          idExFunct;

  instruction_decode_control #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
    .clk                  (clk),
    .resetN               (resetN),
    .programCounterOut    (programCounterOut),
    .instruction          (instruction),
    .rsData               (rsData),
    .rtData               (rtData),
    .pcWrite              (pcWrite),
    .ifIdWrite            (ifIdWrite),
    .branch               (branch),
    .branchProgramCounter (branchProgramCounter),
    .idExRegWrite         (idExRegWrite),
    .idExMemRead          (idExMemRead),
    .idExMemWrite         (idExMemWrite),
    .idExDestReg          (idExDestReg),
    .idExRsData           (idExRsData),
    .idExRtData           (idExRtData),
    .idExImm              (idExImm),
    .idExFunct            (idExFunct)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  dst;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [5:0]  fn;
  } ex_t;

  // Model: what ID/EX holds, how many more cycles the held instruction must
  // wait, and whether the instruction now in IF/ID is a wrong-path fetch.
  ex_t         m_ex, e_next;
  int          m_hold, n_hold;
  bit          m_squash, n_squash;
  logic        e_go, e_br;
  logic [31:0] e_tgt;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic ex_t dut_ex();
    return {idExRegWrite, idExMemRead, idExMemWrite, idExDestReg,
            idExRsData, idExRtData, idExImm, idExFunct};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    bit use_rs, use_rt, dep;
    op = instruction[31:26]; rs = instruction[25:21];
    rt = instruction[20:16]; rd = instruction[15:11];
    e_go = 1'b1; e_br = 1'b0; e_tgt = '0; e_next = '0; n_hold = 0; n_squash = 1'b0;
    if (m_squash) begin
      n_squash = 1'b0;
    end else if (m_hold > 0) begin
      e_go = 1'b0; n_hold = m_hold - 1;
    end else begin
      use_rs = (op != 6'h02);
      use_rt = op inside {6'h00, 6'h2B, 6'h04};
      dep = (m_ex.dst != 0) && ((use_rs && rs == m_ex.dst) || (use_rt && rt == m_ex.dst));
      if (dep && m_ex.mr) begin
        e_go = 1'b0; n_hold = (op == 6'h04) ? 1 : 0;
      end else if (dep && m_ex.rw && op == 6'h04) begin
        e_go = 1'b0;
      end else if (op == 6'h02) begin
        e_br = 1'b1; n_squash = 1'b1;
        e_tgt = {programCounterOut[31:28], instruction[25:0], 2'b00};
      end else if (op == 6'h04) begin
        if (rsData == rtData) begin
          e_br = 1'b1; n_squash = 1'b1;
          e_tgt = programCounterOut + ({{16{instruction[15]}}, instruction[15:0]} << 2);
        end
      end else if (instruction != 0 && op inside {6'h00, 6'h23, 6'h2B}) begin
        e_next.mr  = (op == 6'h23);
        e_next.mw  = (op == 6'h2B);
        e_next.dst = (op == 6'h00) ? rd : (op == 6'h23) ? rt : 5'd0;
        e_next.rw  = (e_next.dst != 0);
        e_next.rsd = rsData;
        e_next.rtd = rtData;
        e_next.imm = {{16{instruction[15]}}, instruction[15:0]};
        e_next.fn  = instruction[5:0];
      end
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    instruction = ins; programCounterOut = pc; rsData = a; rtData = b;
    #1;
    predict();
    chk("pcWrite", 128'(pcWrite), 128'(e_go));
    chk("ifIdWrite", 128'(ifIdWrite), 128'(e_go));
    chk("branch", 128'(branch), 128'(e_br));
    chk("branchPC", 128'(branchProgramCounter), 128'(e_tgt));
  endtask

  task automatic edge_chk();
    @(posedge clk); #1;
    m_ex = e_next; m_hold = n_hold; m_squash = n_squash;
    chk("idEx", 128'(dut_ex()), 128'(m_ex));
    @(negedge clk);
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b);
    drive(ins, pc, a, b);
    edge_chk();
  endtask

  task automatic model_reset();
    m_ex = '0; m_hold = 0; m_squash = 1'b0;
  endtask

  initial begin
    logic [31:0] ins, pc, a, b;
    int sel;
    resetN = 1'b0;
    instruction = 32'h0800_0010; programCounterOut = '0; rsData = '0; rtData = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pcWrite", 128'(pcWrite), 128'(1));
    chk("rst_branch", 128'(branch), 128'(0));
    chk("rst_idEx", 128'(dut_ex()), 128'(0));
    @(negedge clk);
    resetN = 1'b1;

    // add r3,r1,r2
    step(32'h0022_1820, 32'h100, 32'd11, 32'd22);
    chk("add_dest", 128'(idExDestReg), 128'(3));
    chk("add_rw", 128'(idExRegWrite), 128'(1));

    // lw r1,0(r0) then dependent add: one stall cycle
    step(32'h8C01_0000, 32'h104, 32'd0, 32'd0);
    drive(32'h0022_1820, 32'h108, 32'd7, 32'd9);
    chk("lu_pcWrite", 128'(pcWrite), 128'(0));
    edge_chk();
    chk("lu_bubble", 128'(idExRegWrite), 128'(0));
    step(32'h0022_1820, 32'h108, 32'd7, 32'd9);
    chk("lu_add_dest", 128'(idExDestReg), 128'(3));

    // beq r1,r2,+8 taken at PC 16, then flush, then normal
    drive(32'h1022_0008, 32'd16, 32'd5, 32'd5);
    chk("beq_taken", 128'(branch), 128'(1));
    chk("beq_target", 128'(branchProgramCounter), 128'(48));
    edge_chk();
    drive(32'h00A6_2020, 32'd20, 32'd1, 32'd2);
    chk("flush_branch", 128'(branch), 128'(0));
    edge_chk();
    chk("flush_bubble", 128'(idExRegWrite), 128'(0));
    step(32'h00A6_2020, 32'd48, 32'd1, 32'd2);
    chk("after_flush_dest", 128'(idExDestReg), 128'(4));

    // beq not taken, then the next instruction decodes normally
    drive(32'h1022_0008, 32'd52, 32'd5, 32'd6);
    chk("beq_nt", 128'(branch), 128'(0));
    edge_chk();
    step(32'h0022_1820, 32'd56, 32'd3, 32'd4);
    chk("beq_nt_next", 128'(idExDestReg), 128'(3));

    // lw r4 then beq r4,r0 with imm 0x8000 at PC 0: two stalls, wrapped target
    step(32'h8C04_0000, 32'd60, 32'd0, 32'd0);
    drive(32'h1080_8000, 32'd0, 32'd7, 32'd7);
    edge_chk();
    drive(32'h1080_8000, 32'd0, 32'd7, 32'd7);
    chk("lwbeq_stall2", 128'(pcWrite), 128'(0));
    edge_chk();
    drive(32'h1080_8000, 32'd0, 32'd7, 32'd7);
    chk("lwbeq_target", 128'(branchProgramCounter), 128'(32'hFFFE_0000));
    edge_chk();
    step(32'h0000_0000, 32'd4, 32'd0, 32'd0);

    // reset asserted during the second stall cycle
    step(32'h8C04_0000, 32'd64, 32'd0, 32'd0);
    step(32'h1080_0003, 32'd68, 32'd9, 32'd9);
    #1;
    resetN = 1'b0;
    #1;
    chk("mid_rst_pcWrite", 128'(pcWrite), 128'(1));
    chk("mid_rst_ifIdWrite", 128'(ifIdWrite), 128'(1));
    chk("mid_rst_branch", 128'(branch), 128'(0));
    chk("mid_rst_bpc", 128'(branchProgramCounter), 128'(0));
    chk("mid_rst_idEx", 128'(dut_ex()), 128'(0));
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
    drive(32'h1080_0003, 32'd68, 32'd9, 32'd9);
    chk("post_rst_run", 128'(branch), 128'(1));
    edge_chk();
    step(32'h0000_0000, 32'd72, 32'd0, 32'd0);

    // random instruction stream; IF/ID is held whenever the model stalls
    ins = instruction; pc = programCounterOut;
    for (int i = 0; i < 500; i++) begin
      if (e_go) begin
        sel = $urandom_range(0, 7);
        ins = $urandom;
        pc  = $urandom & 32'hFFFF_FFFC;
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        ins[15:11] = 5'($urandom_range(0, 3));
        case (sel)
          0, 1:    ins[31:26] = 6'h00;
          2:       ins[31:26] = 6'h23;
          3:       ins[31:26] = 6'h2B;
          4, 5:    ins[31:26] = 6'h04;
          6:       ins[31:26] = 6'h02;
          default: ins = ($urandom_range(0, 1) == 0) ? 32'h0 : {6'h3F, ins[25:0]};
        endcase
      end
      a = 32'($urandom_range(0, 2));
      b = 32'($urandom_range(0, 2));
      step(ins, pc, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
